// File: rtl/alu_seq.sv
// Sequential execute unit on the alucontrol bus: single-cycle logic/arith, bit-serial shifts.
// Optional signed-overflow output is compiled in with `define ALU_SEQ_OVF_EN.
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       alucontrol,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [4:0]       shamt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
`ifdef ALU_SEQ_OVF_EN
    ,
    output logic             overflow
`endif
);

    typedef enum logic [1:0] {IDLE, SHIFT, FIN} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] sreg, sreg_sh, alu_res, sum, diff;
    logic [4:0]       cnt, amt;
    logic             left, is_shift, alu_ill, accept, go_shift;

    assign busy     = (state == SHIFT);
    assign done     = (state == FIN);
    assign accept   = start && (state != SHIFT);
    assign go_shift = is_shift && (amt != 5'd0);
    assign sreg_sh  = left ? (sreg << 1) : (sreg >> 1);
    assign sum      = a + b;
    assign diff     = a - b;

    // Only the operand an op actually uses reaches alu_res, so X on the other is harmless.
    always_comb begin
        alu_res  = '0;
        alu_ill  = 1'b0;
        is_shift = 1'b0;
        amt      = 5'd0;
        case (alucontrol)
            4'b0000: alu_res = a & b;
            4'b0001: alu_res = a | b;
            4'b0010: alu_res = sum;
            4'b0110: alu_res = diff;
            4'b0111: alu_res = WIDTH'($signed(a) < $signed(b));
            4'b1000: alu_res = WIDTH'({b[15:0], 16'h0000});
            4'b1001: alu_res = a ^ b;
            4'b1010: alu_res = WIDTH'(!(a[WIDTH-1] || (a == '0)));
            4'b0011: begin
                is_shift = 1'b1;
                amt      = shamt;
                alu_res  = b;
            end
            4'b1011: begin
                is_shift = 1'b1;
                amt      = a[4:0];
                alu_res  = b;
            end
            default: alu_ill = 1'b1;
        endcase
    end

`ifdef ALU_SEQ_OVF_EN
    logic alu_ovf;
    always_comb begin
        alu_ovf = 1'b0;
        if (alucontrol == 4'b0010)
            alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        else if (alucontrol == 4'b0110)
            alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
    end
`endif

    always_comb begin
        state_n = state;
        case (state)
            IDLE, FIN: begin
                if (start) state_n = go_shift ? SHIFT : FIN;
                else       state_n = IDLE;
            end
            SHIFT:   if (cnt == 5'd1) state_n = FIN;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            result  <= '0;
            zero    <= 1'b1;
            illegal <= 1'b0;
            sreg    <= '0;
            cnt     <= 5'd0;
            left    <= 1'b0;
`ifdef ALU_SEQ_OVF_EN
            overflow <= 1'b0;
`endif
        end else if (accept) begin
            if (go_shift) begin
                sreg <= b;
                cnt  <= amt;
                left <= (alucontrol == 4'b0011);
            end else begin
                result  <= alu_res;
                zero    <= (alu_res == '0);
                illegal <= alu_ill;
`ifdef ALU_SEQ_OVF_EN
                overflow <= alu_ovf;
`endif
            end
        end else if (state == SHIFT) begin
            sreg <= sreg_sh;
            cnt  <= cnt - 5'd1;
            // Last step: commit the fully shifted value as this completion's result.
            if (cnt == 5'd1) begin
                result  <= sreg_sh;
                zero    <= (sreg_sh == '0);
                illegal <= 1'b0;
`ifdef ALU_SEQ_OVF_EN
                overflow <= 1'b0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: latency/arith model checked every cycle plus literal result checks.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [3:0]  alucontrol;
    logic [31:0] a, b;
    logic [4:0]  shamt;
    logic        busy, done, zero, illegal;
    logic [31:0] result;
`ifdef ALU_SEQ_OVF_EN
    logic        overflow;
`endif

    alu_seq #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .alucontrol(alucontrol),
        .a(a), .b(b), .shamt(shamt), .busy(busy), .done(done),
        .result(result), .zero(zero), .illegal(illegal)
`ifdef ALU_SEQ_OVF_EN
        , .overflow(overflow)
`endif
    );

    always #5 clk = ~clk;

    int          nvec = 0, nfail = 0;
    logic        chk_en = 1'b0;
    logic [31:0] lit_exp = '0;
    logic        lit_on = 1'b0;

    // Model state: remaining busy cycles plus the committed outputs.
    int          m_rem = 0;
    logic        m_done = 1'b0, m_zero = 1'b1, m_ill = 1'b0, m_ovf = 1'b0;
    logic [31:0] m_res = '0, p_res = '0;
    logic        p_ill = 1'b0, p_ovf = 1'b0;
    int          p_lat = 0;

    function automatic void predict(input logic [3:0] op, input logic [31:0] av, bv,
                                    input logic [4:0] sh, output logic [31:0] r,
                                    output logic ill, output int lat, output logic ovf);
        longint s;
        r = '0; ill = 1'b0; lat = 0; ovf = 1'b0;
        case (op)
            4'b0000: r = av & bv;
            4'b0001: r = av | bv;
            4'b0010: begin
                r = av + bv;
                s = longint'($signed(av)) + longint'($signed(bv));
                ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'b0110: begin
                r = av - bv;
                s = longint'($signed(av)) - longint'($signed(bv));
                ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'b0111: r = ($signed(av) < $signed(bv)) ? 32'd1 : 32'd0;
            4'b1000: r = bv << 16;
            4'b1001: r = av ^ bv;
            4'b1010: r = ($signed(av) <= 0) ? 32'd0 : 32'd1;
            4'b0011: begin r = bv << sh;      lat = int'(sh);      end
            4'b1011: begin r = bv >> av[4:0]; lat = int'(av[4:0]); end
            default: ill = 1'b1;
        endcase
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_rem = 0; m_done = 1'b0; m_res = '0; m_zero = 1'b1; m_ill = 1'b0; m_ovf = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_rem > 0) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_res = p_res; m_zero = (p_res == 0); m_ill = p_ill; m_ovf = p_ovf; m_done = 1'b1;
                end
            end else if (start === 1'b1) begin
                predict(alucontrol, a, b, shamt, p_res, p_ill, p_lat, p_ovf);
                if (p_lat == 0) begin
                    m_res = p_res; m_zero = (p_res == 0); m_ill = p_ill; m_ovf = p_ovf; m_done = 1'b1;
                end else begin
                    m_rem = p_lat;
                end
            end
        end
    end

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy",    32'(busy),    32'(m_rem > 0));
            chk("done",    32'(done),    32'(m_done));
            chk("result",  result,       m_res);
            chk("zero",    32'(zero),    32'(m_zero));
            chk("illegal", 32'(illegal), 32'(m_ill));
`ifdef ALU_SEQ_OVF_EN
            chk("overflow", 32'(overflow), 32'(m_ovf));
`endif
            if (m_done && lit_on) chk("literal", result, lit_exp);
        end
    end

    task automatic step();
        @(negedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] av, bv,
                         input logic [4:0] sh, input logic [31:0] lit);
        start = 1'b1; alucontrol = op; a = av; b = bv; shamt = sh;
        lit_exp = lit; lit_on = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 100; i++) begin
            if (done === 1'b1) return;
            step();
        end
        $display("FAIL timeout: done never rose (got 0 expected 1) at %0t", $time);
        $fatal(1);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; alucontrol = '0; a = '0; b = '0; shamt = '0;
        step();
        chk_en = 1'b1;
        step();
        reset = 1'b0;
        idle(3);

        issue(4'b0010, 32'd7, 32'd5, 5'd0, 32'd12);
        wait_done();
        issue(4'b0110, 32'd5, 32'd5, 5'd0, 32'd0);
        wait_done();
        idle(1);

        issue(4'b0011, 32'hxxxx_xxxx, 32'h0000_0001, 5'd4, 32'h0000_0010);
        start = 1'b1; alucontrol = 4'b0000; a = '0; b = '0;
        step();
        start = 1'b0;
        wait_done();
        idle(1);

        issue(4'b1011, 32'd0, 32'hF000_0000, 5'bxxxxx, 32'hF000_0000);
        wait_done();
        issue(4'b1011, 32'd31, 32'hF000_0000, 5'bxxxxx, 32'h0000_0001);
        wait_done();
        idle(1);

        issue(4'b0111, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd1);
        wait_done();
        issue(4'b0111, 32'd1, 32'hFFFF_FFFF, 5'd0, 32'd0);
        wait_done();
        issue(4'b1010, 32'd0, 32'hxxxx_xxxx, 5'd0, 32'd0);
        wait_done();
        issue(4'b1010, 32'd3, 32'hxxxx_xxxx, 5'd0, 32'd1);
        wait_done();
        issue(4'b1010, 32'h8000_0000, 32'd0, 5'd0, 32'd0);
        wait_done();
        idle(1);

        issue(4'b1000, 32'hxxxx_xxxx, 32'h1234_ABCD, 5'bxxxxx, 32'hABCD_0000);
        wait_done();
        issue(4'b0000, 32'h0000_F0F0, 32'h0000_FF00, 5'd0, 32'h0000_F000);
        wait_done();
        issue(4'b0001, 32'h0000_F0F0, 32'h0000_FF00, 5'd0, 32'h0000_FFF0);
        wait_done();
        issue(4'b1001, 32'h0000_F0F0, 32'h0000_FF00, 5'd0, 32'h0000_0FF0);
        wait_done();
        issue(4'b0110, 32'd3, 32'd5, 5'd0, 32'hFFFF_FFFE);
        wait_done();
        issue(4'b0010, 32'h7FFF_FFFF, 32'd1, 5'd0, 32'h8000_0000);
        wait_done();
        issue(4'b0110, 32'h8000_0000, 32'd1, 5'd0, 32'h7FFF_FFFF);
        wait_done();
        idle(1);

        issue(4'b1111, 32'd9, 32'd9, 5'd0, 32'd0);
        wait_done();
        idle(2);

        issue(4'b0011, 32'd0, 32'h0000_0003, 5'd20, 32'h0030_0000);
        idle(5);
        reset = 1'b1;
        step();
        reset = 1'b0;
        idle(25);

        issue(4'b0011, 32'd0, 32'h8000_0001, 5'd1, 32'h0000_0002);
        wait_done();
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
